// File: rtl/camera_dvp_emitter_if.sv
// DVP byte-stream bundle: vertical sync, line valid and the 8-bit pixel byte.
// The emitter drives it through the master modport; a capture block listens on the slave modport.
interface camera_dvp_emitter_if;
    logic       vs;
    logic       href;
    logic [7:0] data;

    modport master (output vs, output href, output data);
    modport slave  (input  vs, input  href, input  data);
endinterface

// File: rtl/camera_dvp_emitter.sv
// OV7670-style DVP source: emits RGB565 test pixels high byte first with parameterised
// frame timing. Every output is a flop loaded from the next-state values.
module camera_dvp_emitter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BLANK    = 144,
    parameter int VS_CYCLES  = 1568,
    parameter int VBP_CYCLES = 784,
    parameter int VFP_CYCLES = 784
) (
    input  logic                  clock_pclk,
    input  logic                  pin_reset,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    input  logic [15:0]           i_color,
    camera_dvp_emitter_if.master  dvp,
    output logic [8:0]            o_row,
    output logic [9:0]            o_col,
    output logic                  o_frame_done,
    output logic [7:0]            o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_LINE   = 3'd3,
        S_HBLANK = 3'd4,
        S_VFP    = 3'd5
    } state_t;

    // One shared cycle counter serves every timed state, so size it for the longest one.
    localparam int M1    = (VS_CYCLES > VBP_CYCLES) ? VS_CYCLES : VBP_CYCLES;
    localparam int M2    = (VFP_CYCLES > H_BLANK) ? VFP_CYCLES : H_BLANK;
    localparam int M3    = (M1 > M2) ? M1 : M2;
    localparam int C_MAX = (M3 > 2 * H_ACTIVE) ? M3 : 2 * H_ACTIVE;
    localparam int CW    = $clog2(C_MAX + 1);

    localparam logic [CW-1:0] C_ZERO    = CW'(0);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] VS_LAST   = CW'(VS_CYCLES - 1);
    localparam logic [CW-1:0] VBP_LAST  = CW'(VBP_CYCLES - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(2 * H_ACTIVE - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VFP_LAST  = CW'(VFP_CYCLES - 1);
    localparam logic [8:0]    ROW_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [9:0]    BAR_LAST  = 10'(H_ACTIVE / 8 - 1);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [9:0]    col_r, col_s;
    logic [8:0]    row_r, row_s;
    logic [9:0]    bar_pix_r, bar_pix_s;
    logic [2:0]    bar_idx_r, bar_idx_s;
    logic [1:0]    mode_r, mode_s;
    logic [15:0]   color_r, color_s;
    logic [7:0]    fcnt_r, fcnt_s;
    logic          done_r, done_s;
    logic          vs_r, vs_s;
    logic          href_r, href_s;
    logic [7:0]    data_r, data_s;
    logic [15:0]   pix_s;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // State, counters and registered outputs.
    always_ff @(posedge clock_pclk or negedge pin_reset) begin
        if (!pin_reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= C_ZERO;
            col_r     <= 10'd0;
            row_r     <= 9'd0;
            bar_pix_r <= 10'd0;
            bar_idx_r <= 3'd0;
            mode_r    <= 2'd0;
            color_r   <= 16'h0000;
            fcnt_r    <= 8'd0;
            done_r    <= 1'b0;
            vs_r      <= 1'b0;
            href_r    <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            col_r     <= col_s;
            row_r     <= row_s;
            bar_pix_r <= bar_pix_s;
            bar_idx_r <= bar_idx_s;
            mode_r    <= mode_s;
            color_r   <= color_s;
            fcnt_r    <= fcnt_s;
            done_r    <= done_s;
            vs_r      <= vs_s;
            href_r    <= href_s;
            data_r    <= data_s;
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        col_s     = col_r;
        row_s     = row_r;
        bar_pix_s = bar_pix_r;
        bar_idx_s = bar_idx_r;
        mode_s    = mode_r;
        color_s   = color_r;
        case (state_r)
            S_IDLE: begin
                if (i_enable) begin
                    state_s = S_VSYNC;
                    cnt_s   = C_ZERO;
                    mode_s  = i_mode;
                    color_s = i_color;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_VSYNC: begin
                if (cnt_r == VS_LAST) begin
                    state_s = S_VBP;
                    cnt_s   = C_ZERO;
                end else begin
                    cnt_s = cnt_r + C_ONE;
                end
            end
            S_VBP: begin
                if (cnt_r == VBP_LAST) begin
                    state_s   = S_LINE;
                    cnt_s     = C_ZERO;
                    col_s     = 10'd0;
                    row_s     = 9'd0;
                    bar_pix_s = 10'd0;
                    bar_idx_s = 3'd0;
                end else begin
                    cnt_s = cnt_r + C_ONE;
                end
            end
            S_LINE: begin
                if (cnt_r == LINE_LAST) begin
                    state_s = S_HBLANK;
                    cnt_s   = C_ZERO;
                    col_s   = 10'd0;
                end else if (cnt_r[0]) begin
                    // Odd byte closes a pixel: step the column and the bar sub-counter together.
                    cnt_s = cnt_r + C_ONE;
                    col_s = col_r + 10'd1;
                    if (bar_pix_r == BAR_LAST) begin
                        bar_pix_s = 10'd0;
                        bar_idx_s = bar_idx_r + 3'd1;
                    end else begin
                        bar_pix_s = bar_pix_r + 10'd1;
                    end
                end else begin
                    cnt_s = cnt_r + C_ONE;
                end
            end
            S_HBLANK: begin
                if (cnt_r == HB_LAST) begin
                    cnt_s     = C_ZERO;
                    bar_pix_s = 10'd0;
                    bar_idx_s = 3'd0;
                    if (row_r == ROW_LAST) begin
                        state_s = S_VFP;
                        row_s   = 9'd0;
                    end else begin
                        state_s = S_LINE;
                        row_s   = row_r + 9'd1;
                    end
                end else begin
                    cnt_s = cnt_r + C_ONE;
                end
            end
            S_VFP: begin
                if (cnt_r == VFP_LAST) begin
                    cnt_s = C_ZERO;
                    if (i_enable) begin
                        state_s = S_VSYNC;
                        mode_s  = i_mode;
                        color_s = i_color;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + C_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = C_ZERO;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        case (mode_s)
            2'd0:    pix_s = color_s;
            2'd1:    pix_s = {row_s[5:0], col_s};
            2'd2:    pix_s = bar_color(bar_idx_s);
            2'd3:    pix_s = (row_s[3] ^ col_s[3]) ? 16'hFFFF : 16'h0000;
            default: pix_s = 16'h0000;
        endcase
        vs_s   = (state_s == S_VSYNC);
        href_s = (state_s == S_LINE);
        if (href_s) begin
            data_s = cnt_s[0] ? pix_s[7:0] : pix_s[15:8];
        end else begin
            data_s = 8'h00;
        end
        done_s = (state_s == S_VFP) && (cnt_s == VFP_LAST);
        if (done_s) begin
            fcnt_s = fcnt_r + 8'd1;
        end else begin
            fcnt_s = fcnt_r;
        end
    end

    assign dvp.vs       = vs_r;
    assign dvp.href     = href_r;
    assign dvp.data     = data_r;
    assign o_row        = row_r;
    assign o_col        = col_r;
    assign o_frame_done = done_r;
    assign o_frame_cnt  = fcnt_r;

endmodule

// File: tb/tb_camera_dvp_emitter.sv
// Directed bench for camera_dvp_emitter with small timing parameters; expected byte
// streams and cycle counts are hand-derived and sampled on the falling clock edge.
module tb_camera_dvp_emitter;

    logic        clk = 1'b0;
    logic        pin_reset;
    logic        i_enable;
    logic [1:0]  i_mode;
    logic [15:0] i_color;
    logic [8:0]  o_row;
    logic [9:0]  o_col;
    logic        o_frame_done;
    logic [7:0]  o_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done = 0;

    logic [7:0]   exp_b [0:3][0:15];
    logic [127:0] bar_line = 128'hFFFFFFE007FF07E0F81FF800001F0000;

    camera_dvp_emitter_if dvp_bus ();

    camera_dvp_emitter #(
        .H_ACTIVE   (8),
        .V_ACTIVE   (4),
        .H_BLANK    (4),
        .VS_CYCLES  (6),
        .VBP_CYCLES (5),
        .VFP_CYCLES (3)
    ) dut (
        .clock_pclk   (clk),
        .pin_reset    (pin_reset),
        .i_enable     (i_enable),
        .i_mode       (i_mode),
        .i_color      (i_color),
        .dvp          (dvp_bus),
        .o_row        (o_row),
        .o_col        (o_col),
        .o_frame_done (o_frame_done),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fill_const(input logic [15:0] c);
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++)
                exp_b[l][b] = b[0] ? c[7:0] : c[15:8];
    endtask

    task automatic fill_bars();
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++)
                exp_b[l][b] = bar_line[127 - 8 * b -: 8];
    endtask

    // Pattern 1 for rows < 64 and cols < 256: high byte is row*4, low byte is col.
    task automatic fill_rowcol();
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++)
                exp_b[l][b] = b[0] ? 8'(b / 2) : 8'(l * 4);
    endtask

    task automatic run_frame(input int exp_cnt, input bit chk_period);
        int n;
        int err;
        err = 0;
        step();
        n = 0;
        while (!dvp_bus.vs && n < 300) begin
            step();
            n++;
        end
        check_eq("vs_seen", {31'd0, dvp_bus.vs}, 32'd1);
        if (!dvp_bus.vs) return;
        check_eq("done_width", {31'd0, o_frame_done}, 32'd0);
        n = 0;
        while (dvp_bus.vs && n < 100) begin
            if (dvp_bus.href || dvp_bus.data != 8'h00) err++;
            n++;
            step();
        end
        check_eq("vs_len", 32'(n), 32'd6);
        n = 0;
        while (!dvp_bus.href && n < 100) begin
            if (dvp_bus.data != 8'h00) err++;
            n++;
            step();
        end
        check_eq("vbp_gap", 32'(n), 32'd5);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 16; b++) begin
                if (!dvp_bus.href || dvp_bus.vs || dvp_bus.data != exp_b[l][b] ||
                    o_row != 9'(l) || o_col != 10'(b / 2)) err++;
                step();
            end
            n = 0;
            if (l < 3) begin
                while (!dvp_bus.href && n < 100) begin
                    if (dvp_bus.data != 8'h00 || o_col != 10'd0) err++;
                    n++;
                    step();
                end
                if (n != 4) err++;
            end else begin
                while (!o_frame_done && n < 100) begin
                    if (dvp_bus.data != 8'h00 || dvp_bus.href || dvp_bus.vs) err++;
                    n++;
                    step();
                end
                if (n != 6) err++;
            end
        end
        check_eq("frame_body_errs", 32'(err), 32'd0);
        check_eq("frame_done", {31'd0, o_frame_done}, 32'd1);
        check_eq("frame_cnt", {24'd0, o_frame_cnt}, 32'(exp_cnt));
        if (chk_period) check_eq("frame_period", 32'(cyc - last_done), 32'd94);
        last_done = cyc;
    endtask

    initial begin
        int n;
        int err;
        pin_reset = 1'b0;
        i_enable  = 1'b0;
        i_mode    = 2'd0;
        i_color   = 16'h0000;
        repeat (2) step();
        check_eq("rst_vs",   {31'd0, dvp_bus.vs},   32'd0);
        check_eq("rst_href", {31'd0, dvp_bus.href}, 32'd0);
        check_eq("rst_data", {24'd0, dvp_bus.data}, 32'd0);
        check_eq("rst_row",  {23'd0, o_row},        32'd0);
        check_eq("rst_col",  {22'd0, o_col},        32'd0);
        check_eq("rst_cnt",  {24'd0, o_frame_cnt},  32'd0);
        check_eq("rst_done", {31'd0, o_frame_done}, 32'd0);
        pin_reset = 1'b1;
        repeat (3) step();
        check_eq("idle_no_enable_vs", {31'd0, dvp_bus.vs}, 32'd0);

        // Mode 2 bars, then continuous frames with per-frame pattern changes.
        i_mode   = 2'd2;
        i_enable = 1'b1;
        fill_bars();
        run_frame(1, 1'b0);

        i_mode  = 2'd0;
        i_color = 16'hA55A;
        fill_const(16'hA55A);
        run_frame(2, 1'b1);

        i_mode = 2'd1;
        fill_rowcol();
        run_frame(3, 1'b1);

        // Mode switched 3 -> 0 mid-frame: this frame stays checkerboard.
        i_mode = 2'd3;
        fill_const(16'h0000);
        fork
            run_frame(4, 1'b1);
            begin
                repeat (40) step();
                i_mode = 2'd0;
            end
        join

        // Enable dropped mid-line: frame still completes, then idle.
        fill_const(16'hA55A);
        fork
            run_frame(5, 1'b1);
            begin
                repeat (50) step();
                i_enable = 1'b0;
            end
        join
        err = 0;
        repeat (20) begin
            step();
            if (dvp_bus.vs || dvp_bus.href || dvp_bus.data != 8'h00 || o_frame_done) err++;
        end
        check_eq("idle_after_disable", 32'(err), 32'd0);
        check_eq("cnt_held_in_idle", {24'd0, o_frame_cnt}, 32'd5);

        // Asynchronous reset in the middle of line 1.
        i_enable = 1'b1;
        n = 0;
        while (!(dvp_bus.href && o_row == 9'd1) && n < 200) begin
            step();
            n++;
        end
        check_eq("reach_line1", {31'd0, dvp_bus.href}, 32'd1);
        repeat (5) step();
        pin_reset = 1'b0;
        #1;
        check_eq("arst_vs",   {31'd0, dvp_bus.vs},   32'd0);
        check_eq("arst_href", {31'd0, dvp_bus.href}, 32'd0);
        check_eq("arst_data", {24'd0, dvp_bus.data}, 32'd0);
        check_eq("arst_row",  {23'd0, o_row},        32'd0);
        check_eq("arst_col",  {22'd0, o_col},        32'd0);
        check_eq("arst_cnt",  {24'd0, o_frame_cnt},  32'd0);
        step();
        pin_reset = 1'b1;
        run_frame(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
